// File: rtl/tdm_pkg.sv
// -----------------------------------------------------------------------------
// tdm_pkg
//   Shared definitions for the TDM de-interleave path.
//   - NUM_CH    : default channel count per TDM frame
//   - OUT_WIDTH : default output lane width
//   - slot_t    : slot index type for the default channel count
//   - lane_t    : one output lane for the default lane width
//   - lane_lsb  : LSB position of lane k inside a packed frame
// -----------------------------------------------------------------------------
package tdm_pkg;

  localparam int NUM_CH    = 2;
  localparam int OUT_WIDTH = 24;

  typedef logic [$clog2(NUM_CH)-1:0] slot_t;
  typedef logic [OUT_WIDTH-1:0]      lane_t;

  // Lane k occupies [k*width +: width] of the packed frame.
  function automatic int lane_lsb(input int k, input int width);
    return k * width;
  endfunction

endpackage

// File: rtl/tdm_slot_counter.sv
// -----------------------------------------------------------------------------
// tdm_slot_counter
//   Tracks which TDM slot the current beat belongs to. A start-of-frame beat
//   always lands in slot 0; if the counter was mid-frame at that moment the
//   frame is misaligned and sync_err pulses one cycle later.
// Ports
//   clk        in   tdm clock, rising edge
//   rst        in   asynchronous active-high reset
//   in_valid   in   beat present this cycle
//   in_sof     in   beat is slot 0 (qualified by in_valid)
//   slot       out  slot of the current beat (combinational)
//   last_beat  out  valid beat in slot NUM_CH-1 (combinational)
//   realign    out  sof seen while mid-frame, this cycle (combinational)
//   sync_err   out  registered one-cycle pulse of realign
// -----------------------------------------------------------------------------
module tdm_slot_counter #(
  parameter  int NUM_CH = 2,
  localparam int SW     = $clog2(NUM_CH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic          in_sof,
  output logic [SW-1:0] slot,
  output logic          last_beat,
  output logic          realign,
  output logic          sync_err
);

  localparam logic [SW-1:0] SLOT_LAST = SW'(NUM_CH - 1);

  logic [SW-1:0] slot_reg;
  logic [SW-1:0] slot_next;
  logic          sync_err_reg;

  always_comb begin
    realign   = in_valid && in_sof && (slot_reg != '0);
    // An sof beat overrides the running count and is kept as slot 0.
    slot      = (in_valid && in_sof) ? '0 : slot_reg;
    last_beat = in_valid && (slot == SLOT_LAST);
    slot_next = slot_reg;
    if (in_valid) begin
      slot_next = last_beat ? '0 : slot + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_reg     <= '0;
      sync_err_reg <= 1'b0;
    end else begin
      slot_reg     <= slot_next;
      sync_err_reg <= realign;
    end
  end

  assign sync_err = sync_err_reg;

endmodule

// File: rtl/tdm_demux_frame.sv
// -----------------------------------------------------------------------------
// tdm_demux_frame
//   De-interleaves the TDM product stream (one channel per beat, channel 0
//   first) into NUM_CH parallel lanes and presents one frame at a time through
//   a valid/ready output register. The last lane is bypassed straight from the
//   beat, so a frame is offered one cycle after its final beat.
//
//   Optional build macro TDM_ACC_EN: each lane keeps a saturating sum over
//   ACC_FRAMES frames and only the window's final frame is offered. Without
//   the macro every completed frame is offered and ACC_FRAMES has no effect.
// Ports
//   clk        in   tdm clock, rising edge
//   rst        in   asynchronous active-high reset
//   in_valid   in   beat present on in_data
//   in_sof     in   beat is slot 0 (qualified by in_valid)
//   in_data    in   interleaved product beat (unsigned)
//   out_valid  out  out_data holds a complete frame
//   out_ready  in   consumer accepts when out_valid && out_ready
//   out_data   out  lane k at [k*OUT_WIDTH +: OUT_WIDTH]
//   sync_err   out  one-cycle pulse: sof arrived mid-frame
//   ovf_err    out  one-cycle pulse: completed frame dropped (output busy)
// -----------------------------------------------------------------------------
module tdm_demux_frame #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_CH     = tdm_pkg::NUM_CH,
  parameter int OUT_WIDTH  = 24,
  parameter int ACC_FRAMES = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic                        in_sof,
  input  logic [DATA_WIDTH-1:0]       in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [NUM_CH*OUT_WIDTH-1:0] out_data,
  output logic                        sync_err,
  output logic                        ovf_err
);

  import tdm_pkg::*;

  localparam int SW = $clog2(NUM_CH);
`ifdef TDM_ACC_EN
  // Every lane, including the last, needs a register to hold its running sum.
  localparam int NUM_STAGE = NUM_CH;
`else
  // The last lane is taken from the beat directly, so it needs no staging.
  localparam int NUM_STAGE = NUM_CH - 1;
`endif

  genvar gi;

  if (NUM_CH < 2 || OUT_WIDTH < DATA_WIDTH || ACC_FRAMES < 1) begin : g_param_check
    $error("tdm_demux_frame: illegal parameter combination");
  end

  // ---------------------------------------------------------------------------
  // Slot tracking
  // ---------------------------------------------------------------------------
  logic [SW-1:0] slot;
  logic          last_beat;
  logic          realign;

  tdm_slot_counter #(
    .NUM_CH (NUM_CH)
  ) u_slot_counter (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_sof    (in_sof),
    .slot      (slot),
    .last_beat (last_beat),
    .realign   (realign),
    .sync_err  (sync_err)
  );

  // ---------------------------------------------------------------------------
  // Lane datapath
  // ---------------------------------------------------------------------------
  logic [OUT_WIDTH-1:0]        beat_ext;
  logic [OUT_WIDTH-1:0]        lane_val   [NUM_CH];
  logic [OUT_WIDTH-1:0]        stage_reg  [NUM_STAGE];
  logic [NUM_CH*OUT_WIDTH-1:0] frame_flat;
  logic                        frame_done;

  assign beat_ext = OUT_WIDTH'(in_data);

`ifdef TDM_ACC_EN
  localparam int                FC_W    = (ACC_FRAMES > 1) ? $clog2(ACC_FRAMES) : 1;
  localparam logic [FC_W-1:0]   FC_LAST = FC_W'(ACC_FRAMES - 1);

  logic [FC_W-1:0] frame_cnt_reg;
  logic [FC_W-1:0] frame_cnt_next;
  logic            acc_first;

  function automatic logic [OUT_WIDTH-1:0] sat_add(input logic [OUT_WIDTH-1:0] a,
                                                   input logic [OUT_WIDTH-1:0] b);
    logic [OUT_WIDTH:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[OUT_WIDTH] ? {OUT_WIDTH{1'b1}} : sum[OUT_WIDTH-1:0];
  endfunction

  // A misaligned sof restarts the window, so its frame loads rather than adds.
  always_comb begin
    acc_first      = (frame_cnt_reg == '0) || realign;
    frame_cnt_next = frame_cnt_reg;
    frame_done     = 1'b0;
    if (realign) begin
      frame_cnt_next = '0;
    end else if (last_beat) begin
      if (frame_cnt_reg == FC_LAST) begin
        frame_done     = 1'b1;
        frame_cnt_next = '0;
      end else begin
        frame_cnt_next = frame_cnt_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt_reg <= '0;
    end else begin
      frame_cnt_reg <= frame_cnt_next;
    end
  end
`else
  assign frame_done = last_beat;
`endif

  for (gi = 0; gi < NUM_CH; gi++) begin : g_lane
`ifdef TDM_ACC_EN
    assign lane_val[gi] = acc_first ? beat_ext : sat_add(stage_reg[gi], beat_ext);
`else
    assign lane_val[gi] = beat_ext;
`endif
    if (gi == NUM_CH - 1) begin : g_bypass
      assign frame_flat[lane_lsb(gi, OUT_WIDTH) +: OUT_WIDTH] = lane_val[gi];
    end else begin : g_staged
      assign frame_flat[lane_lsb(gi, OUT_WIDTH) +: OUT_WIDTH] = stage_reg[gi];
    end
  end

  // Lanes left over from a discarded partial frame are cleared on realign so
  // stale data never reaches the output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_STAGE; k++) begin
        stage_reg[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_STAGE; k++) begin
        if (in_valid && (int'(slot) == k)) begin
          stage_reg[k] <= lane_val[k];
        end else if (realign && (k != 0)) begin
          stage_reg[k] <= '0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output register and handshake. Everything driven out is registered, so
  // out_ready never reaches an output combinationally.
  // ---------------------------------------------------------------------------
  logic                        out_valid_reg;
  logic [NUM_CH*OUT_WIDTH-1:0] out_data_reg;
  logic                        ovf_err_reg;
  logic                        load_frame;

  // Loading over an accepted frame in the same cycle keeps back-to-back
  // frames bubble-free.
  assign load_frame = frame_done && (!out_valid_reg || out_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      ovf_err_reg   <= 1'b0;
    end else begin
      ovf_err_reg <= frame_done && out_valid_reg && !out_ready;
      if (load_frame) begin
        out_valid_reg <= 1'b1;
        out_data_reg  <= frame_flat;
      end else if (out_ready) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign ovf_err   = ovf_err_reg;

endmodule

// File: tb/tb_tdm_demux_frame.sv
// -----------------------------------------------------------------------------
// tb_tdm_demux_frame
//   Directed scenarios followed by random traffic, each cycle compared against
//   a frame-level reference model (slot index, lane array, output slot).
// -----------------------------------------------------------------------------
module tb_tdm_demux_frame;

  localparam int DW   = 16;
  localparam int NCH  = 2;
  localparam int ACCF = 4;
`ifdef TDM_ACC_EN
  localparam int OW = 17;
`else
  localparam int OW = 24;
`endif
  localparam longint LANE_MAX = (longint'(1) << OW) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_sof;
  logic [DW-1:0]     in_data;
  logic              out_valid;
  logic              out_ready;
  logic [NCH*OW-1:0] out_data;
  logic              sync_err;
  logic              ovf_err;

  tdm_demux_frame #(
    .DATA_WIDTH (DW),
    .NUM_CH     (NCH),
    .OUT_WIDTH  (OW),
    .ACC_FRAMES (ACCF)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_sof    (in_sof),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .sync_err  (sync_err),
    .ovf_err   (ovf_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  int          m_slot;
  longint      m_lane [NCH];
  bit          m_valid;
  logic [63:0] m_data;
  bit          m_sync;
  bit          m_ovf;
  int          m_fc;

  function automatic logic [63:0] model_frame();
    logic [63:0] r;
    r = '0;
    for (int k = 0; k < NCH; k++) begin
      r = r | (64'(m_lane[k]) << (k * OW));
    end
    return r;
  endfunction

  task automatic model_reset();
    m_slot  = 0;
    for (int k = 0; k < NCH; k++) m_lane[k] = 0;
    m_valid = 1'b0;
    m_data  = '0;
    m_sync  = 1'b0;
    m_ovf   = 1'b0;
    m_fc    = 0;
  endtask

  task automatic model_step(input bit v, input bit sof, input logic [DW-1:0] d, input bit rdy);
    bit done;
    done   = 1'b0;
    m_sync = 1'b0;
    m_ovf  = 1'b0;
    if (v) begin
      if (sof) begin
        if (m_slot != 0) begin
          m_sync = 1'b1;
          m_fc   = 0;
        end
        m_slot = 0;
      end
`ifdef TDM_ACC_EN
      if (m_fc == 0) m_lane[m_slot] = longint'(d);
      else if (m_lane[m_slot] + longint'(d) > LANE_MAX) m_lane[m_slot] = LANE_MAX;
      else m_lane[m_slot] = m_lane[m_slot] + longint'(d);
`else
      m_lane[m_slot] = longint'(d);
`endif
      if (m_slot == NCH - 1) begin
        m_slot = 0;
`ifdef TDM_ACC_EN
        if (m_fc == ACCF - 1) begin
          done = 1'b1;
          m_fc = 0;
        end else begin
          m_fc++;
        end
`else
        done = 1'b1;
`endif
      end else begin
        m_slot++;
      end
    end
    if (done && (!m_valid || rdy)) begin
      m_valid = 1'b1;
      m_data  = model_frame();
    end else if (done) begin
      m_ovf = 1'b1;
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic step(input bit v, input bit sof, input logic [DW-1:0] d, input bit rdy);
    @(negedge clk);
    in_valid  = v;
    in_sof    = sof;
    in_data   = d;
    out_ready = rdy;
    @(posedge clk);
    model_step(v, sof, d, rdy);
    #1;
    check("out_valid", 64'(out_valid), 64'(m_valid));
    check("out_data", 64'(out_data), m_data);
    check("sync_err", 64'(sync_err), 64'(m_sync));
    check("ovf_err", 64'(ovf_err), 64'(m_ovf));
    $display("t=%0t v=%0b sof=%0b d=%h rdy=%0b | out_valid=%0b out_data=%h sync=%0b ovf=%0b",
             $time, v, sof, d, rdy, out_valid, out_data, sync_err, ovf_err);
  endtask

  // Reset asserted between clock edges; outputs must clear without a clock.
  task automatic mid_reset();
    @(negedge clk);
    in_valid  = 1'b0;
    in_sof    = 1'b0;
    out_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    model_reset();
    check("rst_out_valid", 64'(out_valid), 64'(m_valid));
    check("rst_out_data", 64'(out_data), m_data);
    check("rst_sync_err", 64'(sync_err), 64'(m_sync));
    check("rst_ovf_err", 64'(ovf_err), 64'(m_ovf));
    $display("t=%0t async reset: out_valid=%0b out_data=%h", $time, out_valid, out_data);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    bit          v;
    bit          sof;
    bit          rdy;
    logic [DW-1:0] d;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_sof    = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_out_data", 64'(out_data), 64'd0);
    check("reset_sync_err", 64'(sync_err), 64'd0);
    check("reset_ovf_err", 64'(ovf_err), 64'd0);
    rst = 1'b0;

    // Two aligned frames, consumer always ready.
    step(1, 1, 16'h0011, 1);
    step(1, 0, 16'h0022, 1);
`ifndef TDM_ACC_EN
    check("t1_frame0", 64'(out_data), 64'h0000_0000_2200_0011);
`endif
    step(1, 1, 16'h0033, 1);
    step(1, 0, 16'h0044, 1);
`ifndef TDM_ACC_EN
    check("t1_frame1", 64'(out_data), 64'h0000_0000_4400_0033);
`endif
    step(0, 0, 16'h0000, 1);

    // Backpressure: frame A held, frame B dropped, then A accepted.
    step(1, 1, 16'h00A1, 0);
    step(1, 0, 16'h00A2, 0);
    step(0, 0, 16'h0000, 0);
    step(1, 1, 16'h00B1, 0);
    step(1, 0, 16'h00B2, 0);
    step(0, 0, 16'h0000, 0);
`ifndef TDM_ACC_EN
    check("t2_frame_a_held", 64'(out_data), 64'h0000_0000_A200_00A1);
`endif
    step(0, 0, 16'h0000, 1);
    step(0, 0, 16'h0000, 1);

    // Misalignment: second sof discards the lone 0x5 beat.
    step(1, 1, 16'h0005, 1);
    step(1, 1, 16'h0006, 1);
    step(1, 0, 16'h0007, 1);
`ifndef TDM_ACC_EN
    check("t3_realigned", 64'(out_data), 64'h0000_0000_0700_0006);
`endif
    step(0, 0, 16'h0000, 1);

    // Gap of three idle cycles between slot 0 and slot 1.
    step(1, 1, 16'h0055, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 16'(($urandom)), 1);
    step(1, 0, 16'h0066, 1);
    step(0, 0, 16'h0000, 1);

    // Reset mid-frame with a frame still pending on the output.
    step(1, 1, 16'h0077, 1);
    step(1, 0, 16'h0078, 0);
    step(1, 1, 16'h0099, 0);
    mid_reset();
    step(1, 0, 16'h00AB, 1);
    step(1, 0, 16'h00CD, 1);
`ifndef TDM_ACC_EN
    check("t5_after_reset", 64'(out_data), 64'h0000_0000_CD00_00AB);
`endif
    step(0, 0, 16'h0000, 1);

`ifdef TDM_ACC_EN
    // Saturating accumulation over one full window.
    mid_reset();
    for (int f = 0; f < ACCF; f++) begin
      step(1, 1, 16'hFFFF, 1);
      step(1, 0, 16'h0001, 1);
    end
    check("t6_saturated", 64'(out_data), 64'h0000_0000_0009_FFFF);
    step(0, 0, 16'h0000, 1);
`endif

    // Random traffic: gaps, occasional misaligned sof, random backpressure.
    for (int i = 0; i < 600; i++) begin
      v   = ($urandom_range(0, 3) != 0);
      if (m_slot == 0) sof = v && ($urandom_range(0, 7) != 0);
      else             sof = v && ($urandom_range(0, 9) == 0);
      d   = 16'($urandom_range(0, 16'hFFFF));
      rdy = ($urandom_range(0, 2) != 0);
      step(v, sof, d, rdy);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
